// File: rtl/sha256_round_ctrl_if.sv
// Message word stream into the SHA-256 round controller.
//   msg_valid : source has a word on msg_data
//   msg_ready : controller can take a word (only while loading a block)
//   msg_data  : 32-bit message word, big-endian, word 0 of the block first
// Handshake: a word transfers on a rising clock edge where msg_valid and
// msg_ready are both high. Once msg_valid is raised, the source holds it and
// msg_data steady until that transfer. msg_ready does not depend on msg_valid.
interface sha256_round_ctrl_if;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_data;

  modport master (output msg_valid, output msg_data, input msg_ready);
  modport slave  (input msg_valid, input msg_data, output msg_ready);
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: one 512-bit block per start, one round per cycle.
//   sha256_funcs      : SHA-256 logic functions, one flavour per MODE
//   sha256_round_ctrl : K ROM, W window, a..h working set, H state and the FSM
// Ports of sha256_round_ctrl:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start, init       : begin a block (IDLE only); init=1 reloads H from the IV first
//   abort             : synchronous cancel of the block in flight
//   msg               : message word stream (slave side of sha256_round_ctrl_if)
//   busy              : state != IDLE
//   digest_valid      : H holds a completed digest
//   digest            : {H0..H7}, H0 in [255:224], always driven from H
//   dbg_state         : current FSM state encoding

// MODE 0: a-side  f1 = Sigma0(x),  f2 = Maj(x,y,z)
// MODE 1: e-side  f1 = Sigma1(x),  f2 = Ch(x,y,z)
// MODE 2: schedule f1 = sigma0(x), f2 = sigma1(y) + z
module sha256_funcs #(
  parameter int MODE = 0
) (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic [31:0] f1,
  output logic [31:0] f2
);
  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  logic [31:0] bsig0, bsig1, ssig0, ssig1, ch, maj;

  always_comb begin
    bsig0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    bsig1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    ssig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    ssig1 = rotr(y, 17) ^ rotr(y, 19) ^ (y >> 10);
    ch    = (x & y) ^ (~x & z);
    maj   = (x & y) ^ (x & z) ^ (y & z);
    f1    = (MODE == 0) ? bsig0 : (MODE == 1) ? bsig1 : ssig0;
    f2    = (MODE == 0) ? maj   : (MODE == 1) ? ch    : ssig1 + z;
  end
endmodule

module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     init,
  input  logic                     abort,
  sha256_round_ctrl_if.slave       msg,
  output logic                     busy,
  output logic                     digest_valid,
  output logic [255:0]             digest,
  output logic [1:0]               dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ROUND = 2'd2, UPDATE = 2'd3} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  state_t      state;
  logic [31:0] hr [8];   // chaining state H0..H7
  logic [31:0] wk [8];   // working set a..h (index 0 = a)
  logic [31:0] w  [16];  // schedule window, w[0] = W[t]
  logic [3:0]  wcnt;
  logic [5:0]  t;

  logic [31:0] sig0_a, maj_abc, sig1_e, ch_efg, s0_w1, s1_w14_w9;
  logic [31:0] t1, t2, w_next;

  sha256_funcs #(.MODE(0)) u_a_side (.x(wk[0]), .y(wk[1]), .z(wk[2]), .f1(sig0_a), .f2(maj_abc));
  sha256_funcs #(.MODE(1)) u_e_side (.x(wk[4]), .y(wk[5]), .z(wk[6]), .f1(sig1_e), .f2(ch_efg));
  sha256_funcs #(.MODE(2)) u_sched  (.x(w[1]),  .y(w[14]), .z(w[9]),  .f1(s0_w1),  .f2(s1_w14_w9));

  always_comb begin
    t1     = wk[7] + sig1_e + ch_efg + K[t] + w[0];
    t2     = sig0_a + maj_abc;
    w_next = s1_w14_w9 + s0_w1 + w[0];
  end

  assign digest    = {hr[0], hr[1], hr[2], hr[3], hr[4], hr[5], hr[6], hr[7]};
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      msg.msg_ready <= 1'b0;
      busy          <= 1'b0;
      digest_valid  <= 1'b0;
      wcnt          <= '0;
      t             <= '0;
      for (int i = 0; i < 8; i++) begin
        hr[i] <= IV[i];
        wk[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort in the same cycle masks start
          if (start && !abort) begin
            if (init) begin
              for (int i = 0; i < 8; i++) hr[i] <= IV[i];
            end
            digest_valid  <= 1'b0;
            wcnt          <= '0;
            state         <= LOAD;
            msg.msg_ready <= 1'b1;
            busy          <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state         <= IDLE;
            msg.msg_ready <= 1'b0;
            busy          <= 1'b0;
          end else begin
            // H is stable for the whole of LOAD, so copying it until the first
            // word arrives yields the same a..h as a single first-cycle load.
            if (wcnt == 4'd0) begin
              for (int i = 0; i < 8; i++) wk[i] <= hr[i];
            end
            if (msg.msg_valid) begin
              for (int i = 0; i < 15; i++) w[i] <= w[i+1];
              w[15] <= msg.msg_data;
              wcnt  <= wcnt + 4'd1;
              if (wcnt == 4'd15) begin
                state         <= ROUND;
                t             <= '0;
                msg.msg_ready <= 1'b0;
              end
            end
          end
        end
        ROUND: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_next;
            wk[7] <= wk[6];
            wk[6] <= wk[5];
            wk[5] <= wk[4];
            wk[4] <= wk[3] + t1;
            wk[3] <= wk[2];
            wk[2] <= wk[1];
            wk[1] <= wk[0];
            wk[0] <= t1 + t2;
            t     <= t + 6'd1;
            if (t == 6'(NUM_ROUNDS - 1)) state <= UPDATE;
          end
        end
        UPDATE: begin
          if (!abort) begin
            for (int i = 0; i < 8; i++) hr[i] <= hr[i] + wk[i];
            digest_valid <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          msg.msg_ready <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_round_ctrl.sv
module tb_sha256_round_ctrl;
  localparam int NUM_ROUNDS = 64;

  localparam logic [255:0] IV_D      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst, start, init, abort;
  logic         busy, digest_valid;
  logic [255:0] digest;
  logic [1:0]   dbg_state;

  sha256_round_ctrl_if mif ();

  sha256_round_ctrl #(.NUM_ROUNDS(NUM_ROUNDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .init         (init),
    .abort        (abort),
    .msg          (mif),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest       (digest),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int           checks   = 0;
  int           failures = 0;
  logic [255:0] exp_q [$];
  bit           chk_q [$];   // 0: digest of an intermediate block, not compared
  int           cyc      = 0;
  int           last_hs  = -1000;
  logic         dv_prev  = 1'b0;

  logic [31:0] w_abc [16];
  logic [31:0] w_empty [16];
  logic [31:0] w_b1 [16];
  logic [31:0] w_b2 [16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [255:0] d, input bit chk);
    exp_q.push_back(d);
    chk_q.push_back(chk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (mif.msg_valid && mif.msg_ready) last_hs = cyc;
    if (digest_valid && !dv_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_digest actual=%h", digest);
      end else begin
        logic [255:0] e;
        bit c;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        if (c) check("digest", digest, e);
        check("latency", 256'(cyc - last_hs), 256'(NUM_ROUNDS + 2));
      end
    end
    dv_prev = digest_valid;
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic send_block(input logic [31:0] words[16], input logic ini, input bit gaps);
    int b;
    start = 1'b1;
    init  = ini;
    @(posedge clk); #1;
    start = 1'b0;
    init  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        mif.msg_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      mif.msg_valid = 1'b1;
      mif.msg_data  = words[i];
      b = 0;
      while (!mif.msg_ready && b < 50) begin @(posedge clk); #1; b++; end
      if (!mif.msg_ready) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout word=%0d", i);
        mif.msg_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    mif.msg_valid = 1'b0;
  endtask

  task automatic wait_digest();
    int n = 0;
    int bad_ready = 0;
    int bad_busy = 0;
    while (!digest_valid && n < NUM_ROUNDS + 20) begin
      if (mif.msg_ready) bad_ready++;
      if (!busy) bad_busy++;
      @(posedge clk); #1;
      n++;
    end
    check("digest_valid_seen", 256'(digest_valid), 256'(1));
    check("ready_low_in_rounds", 256'(bad_ready), 256'(0));
    check("busy_in_rounds", 256'(bad_busy), 256'(0));
    check("idle_after_digest", 256'({busy, mif.msg_ready}), 256'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    w_abc   = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
    w_empty = '{32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    w_b1    = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    w_b2    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

    rst = 1'b1; start = 1'b0; init = 1'b0; abort = 1'b0;
    mif.msg_valid = 1'b0; mif.msg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_digest", digest, IV_D);
    check("reset_flags", 256'({busy, digest_valid, mif.msg_ready}), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: "abc"
    push_exp(DIG_ABC, 1'b1);
    send_block(w_abc, 1'b1, 1'b0);
    wait_digest();

    // 2: empty string
    push_exp(DIG_EMPTY, 1'b1);
    send_block(w_empty, 1'b1, 1'b0);
    wait_digest();

    // 3: two-block message, second block chained
    push_exp('0, 1'b0);
    send_block(w_b1, 1'b1, 1'b0);
    wait_digest();
    push_exp(DIG_56, 1'b1);
    send_block(w_b2, 1'b0, 1'b0);
    wait_digest();

    // 4: stray msg_valid in IDLE is ignored, then "abc" with gaps
    mif.msg_valid = 1'b1;
    mif.msg_data  = 32'hdeadbeef;
    repeat (3) begin @(posedge clk); #1; end
    check("stray_valid_idle", 256'({busy, mif.msg_ready}), 256'(0));
    mif.msg_valid = 1'b0;
    push_exp(DIG_ABC, 1'b1);
    send_block(w_abc, 1'b1, 1'b1);
    wait_digest();

    // 5: abort at round 30 of a chained block, then start+abort, then rerun
    push_exp('0, 1'b0);
    send_block(w_b1, 1'b1, 1'b0);
    wait_digest();
    send_block(w_b2, 1'b0, 1'b0);
    repeat (30) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("after_abort", 256'({busy, digest_valid, mif.msg_ready}), 256'(0));
    start = 1'b1; init = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; init = 1'b0; abort = 1'b0;
    check("start_abort_ignored", 256'(busy), 256'(0));
    push_exp(DIG_56, 1'b1);
    send_block(w_b2, 1'b0, 1'b0);
    wait_digest();

    // 6: reset pulsed mid-ROUND, then init=0 run starts from IV
    send_block(w_abc, 1'b1, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset_digest", digest, IV_D);
    check("midrun_reset_flags", 256'({busy, digest_valid, mif.msg_ready}), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_exp(DIG_ABC, 1'b1);
    send_block(w_abc, 1'b0, 1'b0);
    wait_digest();

    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end
endmodule
